fetch: RTL and testbench

Instruction fetch stage of the MIPS core, directly upstream of the `control` decoder. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. It presents each returned instruction, with its opcode/funct/immediate fields split out, to decode for as long as it is needed. It advances sequentially or to a branch target according to the `pc_load` decision fed back from control.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_perf.sv | 26 ++
 rtl/fetch.sv | 97 +++++++++
 tb/tb_fetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_ST_IDLE  = 2'd0,
        FETCH_ST_FETCH = 2'd1,
        FETCH_ST_VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] INSTR_NOP = '0;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory read bus: req/addr out of fetch, ack/data back from memory.
interface fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );

endinterface

// File: rtl/fetch_perf.sv
// Fetch performance counters: accepted acks and FETCH cycles spent waiting.
// Only built when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_hit,
    input  logic        fetch_wait,
    output logic [31:0] fetch_count_o,
    output logic [31:0] wait_count_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_count_o <= '0;
            wait_count_o  <= '0;
        end else begin
            if (fetch_hit)
                fetch_count_o <= fetch_count_o + 32'd1;
            if (fetch_wait)
                wait_count_o <= wait_count_o + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/fetch.sv
// MIPS instruction fetch stage: PC, instruction register and req/ack fetch FSM.
// Optional perf counters (fetch_count_o, wait_count_o) under FETCH_PERF_CNT_EN.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        pc_load_i,
    fetch_if.master     imem,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [5:0]  opcode_o,
    output logic [5:0]  funct_o,
    output logic [15:0] imm_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count_o,
    output logic [31:0] wait_count_o
`endif
);

    fetch_state_t state_q, state_nxt;
    logic [31:0]  pc_q, pc_nxt;
    logic [31:0]  instr_q, instr_nxt;
    logic [31:0]  pc_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= INSTR_NOP;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

    // Branch target uses the held instruction's immediate; wraps modulo 2^32.
    assign pc_sum = pc_q + PC_STEP + (pc_load_i ? branch_offset(instr_q[IMM_MSB:IMM_LSB]) : '0);

    always_comb begin
        state_nxt       = state_q;
        pc_nxt          = pc_q;
        instr_nxt       = instr_q;
        imem.imem_req_o = 1'b0;
        instr_valid_o   = 1'b0;
        case (state_q)
            FETCH_ST_IDLE: begin
                state_nxt = FETCH_ST_FETCH;
            end
            FETCH_ST_FETCH: begin
                imem.imem_req_o = 1'b1;
                if (imem.imem_ack_i) begin
                    instr_nxt = imem.imem_data_i;
                    state_nxt = FETCH_ST_VALID;
                end
            end
            FETCH_ST_VALID: begin
                instr_valid_o = 1'b1;
                if (!stall_i) begin
                    pc_nxt    = {pc_sum[31:2], 2'b00};
                    state_nxt = FETCH_ST_FETCH;
                end
            end
            default: begin
                state_nxt = FETCH_ST_IDLE;
            end
        endcase
    end

    assign imem.imem_addr_o = pc_q;
    assign pc_o             = pc_q;
    assign instr_o          = instr_valid_o ? instr_q : INSTR_NOP;
    assign opcode_o         = instr_o[OPCODE_MSB:OPCODE_LSB];
    assign funct_o          = instr_o[FUNCT_MSB:FUNCT_LSB];
    assign imm_o            = instr_o[IMM_MSB:IMM_LSB];

`ifdef FETCH_PERF_CNT_EN
    logic fetching;
    assign fetching = (state_q == FETCH_ST_FETCH);

    fetch_perf u_perf (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_hit     (fetching && imem.imem_ack_i),
        .fetch_wait    (fetching && !imem.imem_ack_i),
        .fetch_count_o (fetch_count_o),
        .wait_count_o  (wait_count_o)
    );
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch: reset, ack latency, branches, stall, wrap, mid-fetch reset.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_load;
    logic [31:0] pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    int unsigned n_checks;
    int unsigned n_errs;

    fetch_if bus ();

    fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .pc_load_i     (pc_load),
        .imem          (bus),
        .pc_o          (pc),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .opcode_o      (opcode),
        .funct_o       (funct),
        .imm_o         (imm)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o (fetch_count),
        .wait_count_o  (wait_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] addr);
        check({tag, ".req"},   {31'd0, bus.imem_req_o}, 32'd1);
        check({tag, ".addr"},  bus.imem_addr_o, addr);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, ".instr"}, instr, 32'd0);
    endtask

    task automatic check_valid(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, ".req"},   {31'd0, bus.imem_req_o}, 32'd0);
        check({tag, ".pc"},    pc, exp_pc);
        check({tag, ".instr"}, instr, exp_instr);
    endtask

    // beq $1,$2,imm: opcode 4, funct = imm[5:0]
    function automatic logic [31:0] beq_w(input logic [15:0] i);
        return {6'h04, 5'd1, 5'd2, i};
    endfunction

    initial begin
        n_checks = 0;
        n_errs   = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        pc_load  = 1'b0;
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = 32'hDEAD_BEEF;

        repeat (2) step();
        check("rst.req",    {31'd0, bus.imem_req_o}, 32'd0);
        check("rst.addr",   bus.imem_addr_o, 32'h0);
        check("rst.pc",     pc, 32'h0);
        check("rst.valid",  {31'd0, instr_valid}, 32'd0);
        check("rst.instr",  instr, 32'h0);
        check("rst.opcode", {26'd0, opcode}, 32'd0);
        check("rst.funct",  {26'd0, funct}, 32'd0);
        check("rst.imm",    {16'd0, imm}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst.fcnt", fetch_count, 32'd0);
        check("rst.wcnt", wait_count, 32'd0);
`endif

        // Combinational memory: ack held high, answers in the request cycle.
        rst = 1'b0;
        bus.imem_data_i = 32'h8C22_0005;
        step();
        check_fetch("c1", 32'h0);
        step();
        check_valid("c2", 32'h0, 32'h8C22_0005);
        check("c2.opcode", {26'd0, opcode}, 32'h23);
        check("c2.funct",  {26'd0, funct}, 32'h05);
        check("c2.imm",    {16'd0, imm}, 32'h0005);
`ifdef FETCH_PERF_CNT_EN
        check("c2.fcnt", fetch_count, 32'd1);
        check("c2.wcnt", wait_count, 32'd0);
`endif
        bus.imem_data_i = 32'h0043_0820;
        step();
        check_fetch("c3", 32'h4);
        step();
        check_valid("c4", 32'h4, 32'h0043_0820);
        check("c4.funct", {26'd0, funct}, 32'h20);

        bus.imem_data_i = 32'h2108_0001;
        repeat (2) begin
            step();
            step();
        end
        check_valid("pc0c", 32'hC, 32'h2108_0001);

        // Ack delayed: three FETCH cycles without ack, ack on the fourth.
        bus.imem_ack_i  = 1'b0;
        bus.imem_data_i = 32'h0000_0000;
        step();
        check_fetch("dly1", 32'h10);
        step();
        check_fetch("dly2", 32'h10);
        step();
        check_fetch("dly3", 32'h10);
        step();
        check_fetch("dly4", 32'h10);
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = 32'h2108_0010;
        step();
        check_valid("dly.v", 32'h10, 32'h2108_0010);
`ifdef FETCH_PERF_CNT_EN
        check("dly.fcnt", fetch_count, 32'd5);
        check("dly.wcnt", wait_count, 32'd3);
`endif

        for (int i = 0; i < 4; i++) begin
            bus.imem_data_i = (i == 3) ? beq_w(16'hFFFE) : 32'h2108_0001;
            step();
            step();
        end
        check_valid("br1.v", 32'h20, beq_w(16'hFFFE));
        check("br1.imm", {16'd0, imm}, 32'h0000_FFFE);
        pc_load = 1'b1;
        step();
        check_fetch("br1.tgt", 32'h1C);
        pc_load = 1'b0;

        bus.imem_data_i = beq_w(16'h0000);
        step();
        bus.imem_data_i = beq_w(16'h0003);
        step();
        check_fetch("br2.f", 32'h20);
        step();
        check_valid("br2.v", 32'h20, beq_w(16'h0003));
        pc_load = 1'b1;
        step();
        check_fetch("br2.tgt", 32'h30);
        pc_load = 1'b0;

        // Stall with branch pending; stray ack and data must be ignored.
        bus.imem_data_i = beq_w(16'h0010);
        step();
        stall   = 1'b1;
        pc_load = 1'b1;
        bus.imem_data_i = 32'hFFFF_FFFF;
        step();
        check_valid("stl1", 32'h30, beq_w(16'h0010));
        step();
        check_valid("stl2", 32'h30, beq_w(16'h0010));
        stall = 1'b0;
        step();
        check_fetch("stl.tgt", 32'h74);
        pc_load = 1'b0;
        bus.imem_data_i = beq_w(16'h0010);
        step();
        check_valid("stl.next", 32'h74, beq_w(16'h0010));
        step();
        check_fetch("stl.once", 32'h78);

        // Backward branch across zero, then sequential wrap.
        bus.imem_data_i = beq_w(16'hFFE0);
        step();
        pc_load = 1'b1;
        step();
        check_fetch("wrap.br", 32'hFFFF_FFFC);
        pc_load = 1'b0;
        bus.imem_data_i = beq_w(16'h0010);
        step();
        check_valid("wrap.v", 32'hFFFF_FFFC, beq_w(16'h0010));
        step();
        check_fetch("wrap.seq", 32'h0);

        // Reset while a fetch at 0x40 is outstanding.
        bus.imem_data_i = beq_w(16'h000F);
        step();
        pc_load = 1'b1;
        step();
        check_fetch("mr.f", 32'h40);
        pc_load = 1'b0;
        bus.imem_ack_i = 1'b0;
        step();
        check_fetch("mr.pend", 32'h40);
        rst = 1'b1;
        step();
        check("mr.req",   {31'd0, bus.imem_req_o}, 32'd0);
        check("mr.addr",  bus.imem_addr_o, 32'h0);
        check("mr.valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("mr.fcnt", fetch_count, 32'd0);
        check("mr.wcnt", wait_count, 32'd0);
`endif
        rst = 1'b0;
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = 32'h0043_0820;
        step();
        check_fetch("mr.rf", 32'h0);
        step();
        check_valid("mr.rv", 32'h0, 32'h0043_0820);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
